// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction-fetch stage behind the PC register.
//
// One read per PC on an SRAM-like instruction bus (req / addr_ok / data_ok).
// At most one read is outstanding. The PC register advances on the address
// handshake. {pc, inst} is presented to the IF/ID boundary with a
// valid/stall handshake. A redirect (flush_i) discards the output register,
// the hold buffer and any read still in flight.
//
// Optional feature macro: FETCH_ADDR_CHECK_EN
//   defined   : a misaligned PC (pc_i[1:0] != 0) is not sent to the bus. When
//               the output register is free, the stage emits {pc_i, 0} with
//               if_adel_o=1 and advances the PC.
//   undefined : no alignment check. Every PC is fetched as-is and if_adel_o
//               stays 0.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   pc_i            current PC (the PC register q output)
//   pc_en_o         PC register enable: the PC advances on the next edge
//   flush_i         PC redirect, asserted in the same cycle the PC is reloaded
//   id_stall_i      decode is not ready: hold the IF output
//   inst_req_o      bus request
//   inst_addr_o     bus address (always pc_i)
//   inst_addr_ok_i  bus accepted the address this cycle
//   inst_data_ok_i  read data is valid this cycle (never back-pressured)
//   inst_rdata_i    read data
//   if_valid_o      the IF output holds a live instruction
//   if_pc_o         PC of if_inst_o
//   if_inst_o       fetched instruction
//   if_adel_o       fetch address error for this entry
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              pc_en_o,
   input  logic              flush_i,
   input  logic              id_stall_i,
   output logic              inst_req_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   input  logic              inst_addr_ok_i,
   input  logic              inst_data_ok_i,
   input  logic [DATA_W-1:0] inst_rdata_i,
   output logic              if_valid_o,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [DATA_W-1:0] if_inst_o,
   output logic              if_adel_o
);

   typedef enum logic [1:0] {
      S_REQ     = 2'd0,  // presenting pc_i on the bus
      S_WAIT    = 2'd1,  // one read outstanding
      S_HOLD    = 2'd2,  // data parked in the hold buffer, output reg full
      S_DISCARD = 2'd3   // read outstanding but flushed: drop its data
   } state_t;

   // One IF/ID entry. adel travels with the entry it belongs to.
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] inst;
      logic              adel;
   } ent_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] req_pc_q;   // PC of the outstanding read
   ent_t              out_q;      // IF/ID output register
   logic              out_vld_q;
   ent_t              hold_q;     // absorbs data_ok while decode stalls

   logic              out_free;   // output reg can take a new entry this cycle
   logic              hs;         // address handshake this cycle
   logic              misalign;
   logic              load;       // write load_ent into the output reg
   ent_t              load_ent;
   logic              hold_ld;    // park the returning data in the hold buffer

   assign inst_addr_o = pc_i;
   assign if_valid_o  = out_vld_q;
   assign if_pc_o     = out_q.pc;
   assign if_inst_o   = out_q.inst;
   assign if_adel_o   = out_q.adel;

   // The output register is free if it is empty, or if decode takes its
   // entry in this same cycle.
   assign out_free = ~out_vld_q | ~id_stall_i;

   // ---------------------------------------------------------------------
   // Next state and bus/PC controls
   // ---------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      inst_req_o    = 1'b0;
      pc_en_o       = 1'b0;
      hs            = 1'b0;
      misalign      = 1'b0;
      load          = 1'b0;
      load_ent      = '0;
      hold_ld       = 1'b0;

      case (state_q)
         S_REQ: begin
`ifdef FETCH_ADDR_CHECK_EN
            misalign = (pc_i[1:0] != 2'b00);
`endif
            // A flush reloads the PC in this cycle. The old pc_i is stale,
            // so no request is made for it.
            if (!flush_i) begin
               if (misalign) begin
                  // Emit the error entry instead of a bus read. Wait until
                  // the output reg can take it.
                  if (out_free) begin
                     load          = 1'b1;
                     load_ent.pc   = pc_i;
                     load_ent.inst = '0;
                     load_ent.adel = 1'b1;
                     pc_en_o       = 1'b1;
                  end
               end else begin
                  inst_req_o = 1'b1;
                  hs         = inst_addr_ok_i;
                  pc_en_o    = inst_addr_ok_i;
                  if (inst_addr_ok_i)
                     state_d = S_WAIT;
               end
            end
         end

         S_WAIT: begin
            if (inst_data_ok_i) begin
               if (flush_i) begin
                  // The data arrives in the same cycle as the redirect.
                  // Drop it; nothing is left to discard.
                  state_d = S_REQ;
               end else if (out_free) begin
                  load          = 1'b1;
                  load_ent.pc   = req_pc_q;
                  load_ent.inst = inst_rdata_i;
                  load_ent.adel = 1'b0;
                  state_d       = S_REQ;
               end else begin
                  hold_ld = 1'b1;
                  state_d = S_HOLD;
               end
            end else if (flush_i) begin
               state_d = S_DISCARD;
            end
         end

         S_HOLD: begin
            if (flush_i) begin
               state_d = S_REQ;
            end else if (!id_stall_i) begin
               load     = 1'b1;
               load_ent = hold_q;
               state_d  = S_REQ;
            end
         end

         S_DISCARD: begin
            // The flushed read is still owed by the bus. Swallow its data.
            if (inst_data_ok_i)
               state_d = S_REQ;
         end

         default: state_d = S_REQ;
      endcase
   end

   // ---------------------------------------------------------------------
   // State, outstanding PC, hold buffer, output register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_REQ;
         req_pc_q  <= '0;
         hold_q    <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
      end else begin
         state_q <= state_d;

         if (hs)
            req_pc_q <= pc_i;

         if (flush_i)
            hold_q <= '0;
         else if (hold_ld) begin
            hold_q.pc   <= req_pc_q;
            hold_q.inst <= inst_rdata_i;
            hold_q.adel <= 1'b0;
         end

         // A flush wins over everything. A reload wins over consumption,
         // so an entry that decode takes can be replaced in the same edge.
         if (flush_i) begin
            out_vld_q  <= 1'b0;
            out_q.adel <= 1'b0;
         end else if (load) begin
            out_vld_q <= 1'b1;
            out_q     <= load_ent;
         end else if (out_vld_q && !id_stall_i) begin
            out_vld_q  <= 1'b0;
            out_q.adel <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
   localparam int          AW     = 32;
   localparam int          DW     = 32;
   localparam logic [31:0] RST_PC = 32'hbfc00000;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] pc_i;
   logic          pc_en_o;
   logic          flush_i;
   logic          id_stall_i;
   logic          inst_req_o;
   logic [AW-1:0] inst_addr_o;
   logic          inst_addr_ok_i;
   logic          inst_data_ok_i;
   logic [DW-1:0] inst_rdata_i;
   logic          if_valid_o;
   logic [AW-1:0] if_pc_o;
   logic [DW-1:0] if_inst_o;
   logic          if_adel_o;

   always #5 clk = ~clk;

   inst_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .pc_en_o(pc_en_o),
      .flush_i(flush_i), .id_stall_i(id_stall_i),
      .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
      .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
      .inst_rdata_i(inst_rdata_i), .if_valid_o(if_valid_o),
      .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_adel_o(if_adel_o)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        pend;      // memory owes one response
   int          cnt;       // cycles until that response
   logic [31:0] maddr;
   int          lat;       // addr_ok -> data_ok distance for new reads
   logic        aok_en;    // default addr_ok level
   logic [31:0] pc_nxt;    // PC register model
   logic [31:0] new_pc;    // redirect target used with flush_i
   logic [31:0] c_addr;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a == 32'hbfc00000) ? 32'h24080001 : (a ^ 32'h5a5aa5a5);
   endfunction

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Observe one settled cycle. Scoreboard checks and environment updates.
   task automatic monitor();
      exp_t e;
      if (rst) begin
         sb.delete();
         pend   = 1'b0;
         pc_nxt = RST_PC;
         return;
      end
      if (inst_req_o) chk("addr_eq_pc", 64'(inst_addr_o), 64'(pc_i));
      if (flush_i) chk("flush_quiet", 64'({inst_req_o, pc_en_o}), 64'(0));
      if (pend) chk("req_while_busy", 64'(inst_req_o), 64'(0));
`ifdef FETCH_ADDR_CHECK_EN
      if (pc_i[1:0] == 2'b00)
`endif
      chk("pc_en", 64'(pc_en_o), 64'(inst_req_o & inst_addr_ok_i));
      if (if_valid_o && !id_stall_i && !flush_i) begin
         if (sb.size() == 0) chk("unexpected_out", 64'(if_pc_o), 64'hffff_ffff_ffff_ffff);
         else begin
            e = sb.pop_front();
            chk("if_pc", 64'(if_pc_o), 64'(e.pc));
            chk("if_inst", 64'(if_inst_o), 64'(e.inst));
            chk("if_adel", 64'(if_adel_o), 64'(e.adel));
         end
      end
      if (flush_i) sb.delete();
      if (inst_data_ok_i) pend = 1'b0;
      if (inst_req_o && inst_addr_ok_i) begin
         pend  = 1'b1;
         cnt   = lat;
         maddr = inst_addr_o;
         sb.push_back('{inst_addr_o, memfn(inst_addr_o), 1'b0});
      end
`ifdef FETCH_ADDR_CHECK_EN
      if (!flush_i && pc_en_o && pc_i[1:0] != 2'b00)
         sb.push_back('{pc_i, 32'd0, 1'b1});
`endif
      pc_nxt = flush_i ? new_pc : (pc_en_o ? pc_i + 32'd4 : pc_i);
   endtask

   task automatic drive();
      pc_i           = pc_nxt;
      inst_addr_ok_i = aok_en;
      flush_i        = 1'b0;
      inst_data_ok_i = 1'b0;
      inst_rdata_i   = $urandom;
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            inst_data_ok_i = 1'b1;
            inst_rdata_i   = memfn(maddr);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic wait_hs(output logic [31:0] a);
      a = '0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (inst_req_o && inst_addr_ok_i) begin a = inst_addr_o; return; end
         step();
      end
      chk("hs_timeout", 64'(1), 64'(0));
   endtask

   task automatic wait_dok();
      for (int i = 0; i < 30; i++) begin
         #1;
         if (inst_data_ok_i) return;
         step();
      end
      chk("dok_timeout", 64'(1), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; aok_en = 1'b0; lat = 1; id_stall_i = 1'b0;
      new_pc = RST_PC; pc_nxt = RST_PC; pend = 1'b0; cnt = 0; maddr = '0;
      drive();
      step(); step();
      #1;
      // reset state
      chk("rst_valid", 64'(if_valid_o), 64'(0));
      chk("rst_pc", 64'(if_pc_o), 64'(0));
      chk("rst_inst", 64'(if_inst_o), 64'(0));
      chk("rst_adel", 64'(if_adel_o), 64'(0));
      chk("rst_req", 64'(inst_req_o), 64'(1));
      chk("rst_addr", 64'(inst_addr_o), 64'(RST_PC));

      // first fetch after reset, data one cycle after addr_ok
      step();
      rst = 1'b0; aok_en = 1'b1; inst_addr_ok_i = 1'b1;
      #1;
      chk("t1_req", 64'(inst_req_o), 64'(1));
      chk("t1_addr", 64'(inst_addr_o), 64'(RST_PC));
      chk("t1_pc_en", 64'(pc_en_o), 64'(1));
      step(); #1;
      chk("t1_notyet", 64'(if_valid_o), 64'(0));
      chk("t1_wait_noreq", 64'(inst_req_o), 64'(0));
      aok_en = 1'b0;
      step(); #1;
      chk("t1_valid", 64'(if_valid_o), 64'(1));
      chk("t1_if_pc", 64'(if_pc_o), 64'(RST_PC));
      chk("t1_if_inst", 64'(if_inst_o), 64'h24080001);

      // addr_ok withheld: request and address held, PC frozen
      chk("t2_req0", 64'(inst_req_o), 64'(1));
      chk("t2_pc_en0", 64'(pc_en_o), 64'(0));
      for (int i = 0; i < 2; i++) begin
         step(); #1;
         chk("t2_req", 64'(inst_req_o), 64'(1));
         chk("t2_addr", 64'(inst_addr_o), 64'hbfc00004);
         chk("t2_pc_en", 64'(pc_en_o), 64'(0));
      end
      step();
      aok_en = 1'b1; inst_addr_ok_i = 1'b1;
      #1;
      chk("t2_hs_pc_en", 64'(pc_en_o), 64'(1));
      chk("t2_hs_addr", 64'(inst_addr_o), 64'hbfc00004);

      // decode stall with a full output reg: data goes to the hold buffer
      id_stall_i = 1'b1;
      step();
      wait_hs(c_addr);
      chk("t3_hs_addr", 64'(c_addr), 64'hbfc00008);
      chk("t3_out_full", 64'(if_valid_o), 64'(1));
      step();
      wait_dok();
      step();
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_hold_noreq", 64'(inst_req_o), 64'(0));
         chk("t3_hold_out", 64'(if_pc_o), 64'hbfc00004);
         step();
      end
      id_stall_i = 1'b0;
      #1;
      chk("t3_release_noreq", 64'(inst_req_o), 64'(0));
      step(); #1;
      chk("t3_held_valid", 64'(if_valid_o), 64'(1));
      chk("t3_held_pc", 64'(if_pc_o), 64'(c_addr));
      chk("t3_held_inst", 64'(if_inst_o), 64'(memfn(c_addr)));
      chk("t3_req_resume", 64'(inst_req_o), 64'(1));
      chk("t3_req_addr", 64'(inst_addr_o), 64'hbfc0000c);

      // flush while waiting: the late data is dropped, fetch restarts at 0x380
      lat = 3;
      step();
      flush_i = 1'b1; new_pc = 32'hbfc00380;
      #1;
      chk("t4_flush_req", 64'(inst_req_o), 64'(0));
      chk("t4_flush_pc_en", 64'(pc_en_o), 64'(0));
      step(); #1;
      chk("t4_disc_req", 64'(inst_req_o), 64'(0));
      chk("t4_disc_valid", 64'(if_valid_o), 64'(0));
      wait_dok();
      step(); #1;
      chk("t4_drop_valid", 64'(if_valid_o), 64'(0));
      chk("t4_new_req", 64'(inst_req_o), 64'(1));
      chk("t4_new_addr", 64'(inst_addr_o), 64'hbfc00380);
      lat = 1;

      // flush together with data_ok: dropped, straight back to REQ
      step();
      flush_i = 1'b1; new_pc = 32'hbfc00400;
      #1;
      step(); #1;
      chk("t5_req", 64'(inst_req_o), 64'(1));
      chk("t5_addr", 64'(inst_addr_o), 64'hbfc00400);
      chk("t5_valid", 64'(if_valid_o), 64'(0));

      // misaligned PC
      step(); step();
      flush_i = 1'b1; new_pc = 32'hbfc00002;
      #1;
      step(); #1;
`ifdef FETCH_ADDR_CHECK_EN
      chk("t6_noreq", 64'(inst_req_o), 64'(0));
      chk("t6_pc_en", 64'(pc_en_o), 64'(1));
      step(); #1;
      chk("t6_valid", 64'(if_valid_o), 64'(1));
      chk("t6_adel", 64'(if_adel_o), 64'(1));
      chk("t6_pc", 64'(if_pc_o), 64'hbfc00002);
      chk("t6_inst", 64'(if_inst_o), 64'(0));
`else
      chk("t6_req", 64'(inst_req_o), 64'(1));
      chk("t6_addr", 64'(inst_addr_o), 64'hbfc00002);
      chk("t6_pc_en", 64'(pc_en_o), 64'(1));
      step(); step(); #1;
      chk("t6_valid", 64'(if_valid_o), 64'(1));
      chk("t6_adel", 64'(if_adel_o), 64'(0));
      chk("t6_pc", 64'(if_pc_o), 64'hbfc00002);
      chk("t6_inst", 64'(if_inst_o), 64'(memfn(32'hbfc00002)));
`endif
      flush_i = 1'b1; new_pc = 32'hbfc00100;

      // random traffic: stalls, addr_ok gaps, latencies, redirects
      for (int i = 0; i < 300; i++) begin
         step();
         id_stall_i     = ($urandom_range(0, 3) == 0);
         inst_addr_ok_i = 1'($urandom_range(0, 1));
         lat            = $urandom_range(1, 3);
         if ($urandom_range(0, 19) == 0) begin
            flush_i = 1'b1;
            new_pc  = 32'hbfc00000 + (32'($urandom_range(0, 255)) << 2);
         end
      end
      step();
      id_stall_i = 1'b0; aok_en = 1'b0; inst_addr_ok_i = 1'b0;
      for (int i = 0; i < 12; i++) step();
      chk("drain_empty", 64'(sb.size()), 64'(0));

      // reset in the middle of an outstanding read
      aok_en = 1'b1; lat = 3;
      step();
      wait_hs(c_addr);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("t8_valid", 64'(if_valid_o), 64'(0));
      chk("t8_req", 64'(inst_req_o), 64'(1));
      chk("t8_addr", 64'(inst_addr_o), 64'(RST_PC));
      chk("t8_pc", 64'(if_pc_o), 64'(0));
      for (int i = 0; i < 6; i++) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
